uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, frame payload width.
REQ-003 SHALL have parameter BUSY_TO, default 15, cycles allowed for tx_busy to rise after a launch.
REQ-004 SHALL have port CLK  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  N_REQ  per-requester frame request, held until acked.
REQ-007 SHALL have port req_data  in  N_REQ*DATA_W  per-requester payload, slice i = bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_par_en  in  N_REQ  per-requester parity enable.
REQ-009 SHALL have port req_par_typ  in  N_REQ  per-requester parity type (0 even, 1 odd).
REQ-010 SHALL have port req_ack  out  N_REQ  one-cycle pulse; frame of requester i accepted into the transmitter.
REQ-011 SHALL have port tx_p_data  out  DATA_W  payload to the transmitter.
REQ-012 SHALL have ports tx_par_en, tx_par_typ  out  1 each  parity controls to the transmitter.
REQ-013 SHALL have port tx_data_valid  out  1  one-cycle launch strobe to the transmitter.
REQ-014 SHALL have port tx_busy  in  1  transmitter busy flag.
REQ-015 SHALL have port grant_id  out  clog2(N_REQ)  index of the current/last granted requester.
REQ-016 SHALL have port arb_busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port err_timeout  out  1  sticky; set when tx_busy fails to rise within BUSY_TO cycles.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE (plus GAP when configured).
REQ-019 IDLE: with tx_busy low and any req_valid high, SHALL pick a winner by round-robin starting at (last grant + 1) mod N_REQ, register data/parity/grant_id, pulse req_ack[winner], go to LAUNCH.
REQ-020 IDLE with tx_busy high SHALL not grant (external transmitter still draining).
REQ-021 LAUNCH SHALL assert tx_data_valid for exactly one cycle with registered tx_p_data/tx_par_en/tx_par_typ, then go to WAIT_BUSY.
REQ-022 tx_p_data, tx_par_en, tx_par_typ SHALL stay stable from LAUNCH until return to IDLE.
REQ-023 WAIT_BUSY SHALL move to WAIT_DONE on first cycle tx_busy=1; after BUSY_TO cycles without it SHALL set err_timeout and return to IDLE.
REQ-024 WAIT_DONE SHALL return to IDLE on first cycle tx_busy=0.
REQ-025 Launch latency: tx_data_valid SHALL rise exactly 1 cycle after the req_ack pulse.
REQ-026 Requests changing while not in IDLE SHALL be ignored; only IDLE samples req_valid.
REQ-027 Round-robin pointer SHALL wrap from N_REQ-1 to 0; a sole requester SHALL win every round.
REQ-028 err_timeout SHALL clear only on RST.

Reset
REQ-029 RST SHALL force IDLE; req_ack=0, tx_data_valid=0, tx_p_data=0, tx_par_en=0, tx_par_typ=0, grant_id=N_REQ-1 (so requester 0 has first priority), arb_busy=0, err_timeout=0, timeout counter=0.
REQ-030 RST asserted mid-frame SHALL abort immediately; no further req_ack or tx_data_valid until released.

Configuration
REQ-031 Macro UART_TX_ARB_GAP_EN SHALL, when defined, add state GAP between WAIT_DONE and IDLE holding for GAP_CYC cycles (parameter, default 2), arb_busy high.
REQ-032 Without UART_TX_ARB_GAP_EN, WAIT_DONE SHALL go directly to IDLE and GAP_CYC SHALL not exist.

Structure
REQ-033 Package uart_tx_arb_pkg SHALL hold the state typedef and default parameter constants.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out).

Verification
REQ-035 Single request: req_valid=0001, data 0xA5, par_en=1, typ=0 -> req_ack[0] pulse, next cycle tx_data_valid=1, tx_p_data=0xA5, tx_par_en=1.
REQ-036 All four request continuously -> grants in order 0,1,2,3,0; one ack per frame.
REQ-037 Transmitter model never raises tx_busy -> err_timeout=1 after 15 cycles in WAIT_BUSY, FSM back in IDLE.
REQ-038 tx_busy held high at reset release with req_valid=0010 -> no ack until tx_busy falls.
REQ-039 RST pulse during WAIT_DONE -> all outputs at reset values next cycle; grant order restarts at 0.
REQ-040 With UART_TX_ARB_GAP_EN, GAP_CYC=2 -> exactly 2 cycles between tx_busy fall and next req_ack.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
// Optional feature macro: UART_TX_ARB_GAP_EN adds an inter-frame GAP state.
package uart_tx_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_BUSY_TO = 15;

`ifdef UART_TX_ARB_GAP_EN
  localparam int DEF_GAP_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } arb_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } arb_state_t;
`endif

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Round-robin selector: scans requesters starting one past the pointer
// and returns the first active one as a one-hot grant plus its index.
module rr_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N     = DEF_N_REQ,
  parameter int IDX_W = $clog2(DEF_N_REQ)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the ring from ptr+1 around to ptr itself; first hit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates several frame requesters onto one UART transmitter.
// Optional feature macro: UART_TX_ARB_GAP_EN inserts GAP_CYC idle cycles
// after each frame before the next grant.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DATA_W  = DEF_DATA_W,
`ifdef UART_TX_ARB_GAP_EN
  parameter int GAP_CYC = DEF_GAP_CYC,
`endif
  parameter int BUSY_TO = DEF_BUSY_TO
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_par_en,
  input  logic [N_REQ-1:0]           req_par_typ,
  output logic [N_REQ-1:0]           req_ack,
  output logic [DATA_W-1:0]          tx_p_data,
  output logic                       tx_par_en,
  output logic                       tx_par_typ,
  output logic                       tx_data_valid,
  input  logic                       tx_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       arb_busy,
  output logic                       err_timeout
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TO_W  = $clog2(BUSY_TO + 1);

  arb_state_t        state, state_nxt;
  logic [N_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]  win_idx;
  logic              grant_ok;
  logic              busy_timeout;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] sel_data;
  logic              sel_par_en;
  logic              sel_par_typ;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (grant_id),
    .grant     (win_onehot),
    .grant_idx (win_idx)
  );

  assign grant_ok     = (state == ST_IDLE) && !tx_busy && (|req_valid);
  assign busy_timeout = (state == ST_WAIT_BUSY) && !tx_busy &&
                        (to_cnt == TO_W'(BUSY_TO - 1));

`ifdef UART_TX_ARB_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_done;

  assign gap_done = (state == ST_GAP) && (gap_cnt == GAP_W'(GAP_CYC - 1));

  // Count cycles spent in GAP so the hold length is exact
  always_ff @(posedge CLK) begin
    if (RST)                 gap_cnt <= '0;
    else if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
    else                     gap_cnt <= '0;
  end
`endif

  // Pick out the winning requester's payload and parity controls
  always_comb begin
    sel_data    = '0;
    sel_par_en  = 1'b0;
    sel_par_typ = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_data    = req_data[i*DATA_W +: DATA_W];
        sel_par_en  = req_par_en[i];
        sel_par_typ = req_par_typ[i];
      end
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (grant_ok) state_nxt = ST_LAUNCH;
      ST_LAUNCH:    state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy)           state_nxt = ST_WAIT_DONE;
        else if (busy_timeout) state_nxt = ST_IDLE;
      end
`ifdef UART_TX_ARB_GAP_EN
      ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_GAP;
      ST_GAP:       if (gap_done) state_nxt = ST_IDLE;
`else
      ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_IDLE;
`endif
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and status; reset suppresses the strobes in the same cycle
  always_comb begin
    req_ack       = (grant_ok && !RST) ? win_onehot : '0;
    tx_data_valid = (state == ST_LAUNCH) && !RST;
    arb_busy      = (state != ST_IDLE);
  end

  // Latch the winner's frame at grant time and hold it until the next grant
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_p_data  <= '0;
      tx_par_en  <= 1'b0;
      tx_par_typ <= 1'b0;
      grant_id   <= IDX_W'(N_REQ - 1);
    end else if (grant_ok) begin
      tx_p_data  <= sel_data;
      tx_par_en  <= sel_par_en;
      tx_par_typ <= sel_par_typ;
      grant_id   <= win_idx;
    end
  end

  // Watch for tx_busy after a launch; a miss sets the sticky error
  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_WAIT_BUSY && !tx_busy && !busy_timeout)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;
      if (busy_timeout)
        err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed, table-driven bench for uart_tx_arb (4 requesters, 8-bit data).
// Builds with or without UART_TX_ARB_GAP_EN; the gap length is folded into
// the expected inter-frame delay.
module tb_uart_tx_arb;

`ifdef UART_TX_ARB_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_par_en;
  logic [3:0]  req_par_typ;
  logic [3:0]  req_ack;
  logic [7:0]  tx_p_data;
  logic        tx_par_en;
  logic        tx_par_typ;
  logic        tx_data_valid;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        err_timeout;

  uart_tx_arb #(
    .N_REQ   (4),
    .DATA_W  (8),
`ifdef UART_TX_ARB_GAP_EN
    .GAP_CYC (2),
`endif
    .BUSY_TO (15)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_par_en    (req_par_en),
    .req_par_typ   (req_par_typ),
    .req_ack       (req_ack),
    .tx_p_data     (tx_p_data),
    .tx_par_en     (tx_par_en),
    .tx_par_typ    (tx_par_typ),
    .tx_data_valid (tx_data_valid),
    .tx_busy       (tx_busy),
    .grant_id      (grant_id),
    .arb_busy      (arb_busy),
    .err_timeout   (err_timeout)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] rv;
    logic       busy;
    logic [3:0] ack;
    logic       tdv;
    logic [1:0] gid;
    logic       ab;
    logic       chk_ab;
    logic       chk_data;
  } vec_t;

  vec_t       tab[$];
  logic [7:0] data_tab [4] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
  logic [3:0] par_en_c  = 4'b1011;
  logic [3:0] par_typ_c = 4'b0110;
  logic       exp_err;
  int         total = 0;
  int         bad   = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] rv, input logic busy);
    req_valid = rv;
    tx_busy   = busy;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    compare($sformatf("row%0d ack", idx), req_ack, v.ack);
    compare($sformatf("row%0d tdv", idx), tx_data_valid, v.tdv);
    compare($sformatf("row%0d gid", idx), grant_id, v.gid);
    compare($sformatf("row%0d err", idx), err_timeout, exp_err);
    if (v.chk_ab)
      compare($sformatf("row%0d arb_busy", idx), arb_busy, v.ab);
    if (v.chk_data) begin
      compare($sformatf("row%0d data", idx), tx_p_data, data_tab[v.gid]);
      compare($sformatf("row%0d par_en", idx), tx_par_en, par_en_c[v.gid]);
      compare($sformatf("row%0d par_typ", idx), tx_par_typ, par_typ_c[v.gid]);
    end
  endtask

  task automatic checkReset(input string tag);
    compare({tag, " ack"}, req_ack, 4'b0000);
    compare({tag, " tdv"}, tx_data_valid, 1'b0);
    compare({tag, " data"}, tx_p_data, 8'h00);
    compare({tag, " par_en"}, tx_par_en, 1'b0);
    compare({tag, " par_typ"}, tx_par_typ, 1'b0);
    compare({tag, " gid"}, grant_id, 2'd3);
    compare({tag, " arb_busy"}, arb_busy, 1'b0);
    compare({tag, " err"}, err_timeout, 1'b0);
  endtask

  // One frame: grant, launch, busy rises, busy held, busy falls, two idle rows
  // (idle rows skip arb_busy so the same table fits the gap build).
  task automatic addFrame(input logic [3:0] rv, input logic [1:0] prev, input logic [1:0] g);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    tab.push_back('{rv,      1'b0, oh,      1'b0, prev, 1'b0, 1'b1, 1'b0});
    tab.push_back('{4'b1010, 1'b0, 4'b0000, 1'b1, g,    1'b1, 1'b1, 1'b1});
    tab.push_back('{4'b1010, 1'b1, 4'b0000, 1'b0, g,    1'b1, 1'b1, 1'b1});
    tab.push_back('{4'b1010, 1'b1, 4'b0000, 1'b0, g,    1'b1, 1'b1, 1'b1});
    tab.push_back('{4'b1010, 1'b0, 4'b0000, 1'b0, g,    1'b1, 1'b1, 1'b1});
    tab.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, g,    1'b0, 1'b0, 1'b1});
    tab.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, g,    1'b0, 1'b0, 1'b1});
  endtask

  task automatic runTable(input string tag);
    foreach (tab[i]) begin
      applyStimulus(tab[i].rv, tab[i].busy);
      #1;
      checkOutput(tab[i], i);
      tick();
    end
    $display("[TB] %s: %0d rows applied", tag, tab.size());
  endtask

  // Hard stop in case something stalls the sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    req_data    = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
    req_par_en  = par_en_c;
    req_par_typ = par_typ_c;
    exp_err     = 1'b0;
    RST         = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    tick();
    tick();
    checkReset("reset");
    RST = 1'b0;

    // Sole requester, wrap with sole requester, full round-robin, sparse set
    addFrame(4'b0001, 2'd3, 2'd0);
    addFrame(4'b0001, 2'd0, 2'd0);
    addFrame(4'b1111, 2'd0, 2'd1);
    addFrame(4'b1111, 2'd1, 2'd2);
    addFrame(4'b1111, 2'd2, 2'd3);
    addFrame(4'b1111, 2'd3, 2'd0);
    addFrame(4'b0101, 2'd0, 2'd2);
    addFrame(4'b0101, 2'd2, 2'd0);
    runTable("phase1");

    // Transmitter never raises busy: 15 waiting cycles, then sticky error
    applyStimulus(4'b0010, 1'b0);
    #1;
    compare("to ack", req_ack, 4'b0010);
    tick();
    applyStimulus(4'b0000, 1'b0);
    #1;
    compare("to launch", tx_data_valid, 1'b1);
    compare("to gid", grant_id, 2'd1);
    tick();
    for (int i = 0; i < 15; i++) begin
      compare($sformatf("to wait%0d err", i), err_timeout, 1'b0);
      compare($sformatf("to wait%0d arb_busy", i), arb_busy, 1'b1);
      tick();
    end
    compare("to err set", err_timeout, 1'b1);
    compare("to back idle", arb_busy, 1'b0);
    tick();
    tick();
    compare("to err sticky", err_timeout, 1'b1);

    // Reset with tx_busy high; no grant until busy falls
    RST = 1'b1;
    applyStimulus(4'b0010, 1'b1);
    tick();
    tick();
    checkReset("reset2");
    RST = 1'b0;
    #1;
    compare("busyhi ack0", req_ack, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      compare($sformatf("busyhi ack%0d", i + 1), req_ack, 4'b0000);
      compare($sformatf("busyhi idle%0d", i + 1), arb_busy, 1'b0);
    end
    applyStimulus(4'b0010, 1'b0);
    #1;
    compare("busyfall ack", req_ack, 4'b0010);
    tick();
    applyStimulus(4'b0000, 1'b0);
    #1;
    compare("busyfall launch", tx_data_valid, 1'b1);
    compare("busyfall data", tx_p_data, 8'h3C);
    compare("busyfall par_en", tx_par_en, 1'b1);
    compare("busyfall par_typ", tx_par_typ, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    compare("wait_done arb_busy", arb_busy, 1'b1);

    // Reset pulse in WAIT_DONE aborts the frame
    RST = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    #1;
    compare("rst mid ack", req_ack, 4'b0000);
    compare("rst mid tdv", tx_data_valid, 1'b0);
    tick();
    RST = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    #1;
    checkReset("post abort");

    // Grant order restarts at requester 0
    tab.delete();
    addFrame(4'b1111, 2'd3, 2'd0);
    addFrame(4'b1111, 2'd0, 2'd1);
    addFrame(4'b1111, 2'd1, 2'd2);
    addFrame(4'b1111, 2'd2, 2'd3);
    addFrame(4'b1111, 2'd3, 2'd0);
    runTable("phase2");

    // Delay from tx_busy falling to the next grant, request held throughout
    applyStimulus(4'b0001, 1'b0);
    #1;
    compare("gap first ack", req_ack, 4'b0001);
    tick();
    applyStimulus(4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0001, 1'b0);
    #1;
    compare("gap fall ack", req_ack, 4'b0000);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (req_ack != 4'b0000) begin
        n = i;
        break;
      end
    end
    compare("gap delay", n, 1 + GAP);
    applyStimulus(4'b0000, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
